// File: rtl/mvm_pkg.sv
// Shared widths, pipeline latencies and FSM encoding for the matrix-vector engine.
package mvm_pkg;

    localparam int IWIDTH_DEF  = 8;
    localparam int OWIDTH_DEF  = 32;
    localparam int AWIDTH_DEF  = 9;
    localparam int LANES       = 8;
    localparam int DOT_LATENCY = 5;
    localparam int MEM_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mvm_ctrl.sv
// Sequences matrix/vector memory reads into the dot8 unit and accumulates the
// returning per-chunk dot products into one result per matrix row.
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_DEF,
    parameter int OWIDTH = OWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AWIDTH-1:0]         num_rows,
    input  logic [AWIDTH-1:0]         num_chunks,
    output logic [AWIDTH-1:0]         mat_raddr,
    output logic [AWIDTH-1:0]         vec_raddr,
    output logic                      mem_ren,
    input  logic [LANES*IWIDTH-1:0]   mat_rdata,
    input  logic [LANES*IWIDTH-1:0]   vec_rdata,
    output logic [LANES*IWIDTH-1:0]   dot_vec0,
    output logic [LANES*IWIDTH-1:0]   dot_vec1,
    output logic                      dot_ivalid,
    input  logic [OWIDTH-1:0]         dot_result,
    input  logic                      dot_ovalid,
    output logic [OWIDTH-1:0]         res_data,
    output logic [AWIDTH-1:0]         res_row,
    output logic                      res_valid,
    output logic                      busy,
    output logic                      done
);

    state_e              state_q;
    logic [AWIDTH-1:0]   n_q, k_q;
    logic [AWIDTH-1:0]   c_q, r_q, addr_q;
    logic [AWIDTH-1:0]   rc_q, rr_q;
    logic [OWIDTH-1:0]   acc_q;
    logic                mem_ren_q, ivalid_q;
    logic [AWIDTH-1:0]   mat_raddr_q, vec_raddr_q;
    logic [OWIDTH-1:0]   res_data_q;
    logic [AWIDTH-1:0]   res_row_q;
    logic                res_valid_q, busy_q, done_q;

    logic                issue_last_col_d, issue_last_row_d;
    logic                ret_fire_d, ret_last_col_d, ret_last_row_d;
    logic [OWIDTH-1:0]   sum_d;

    assign issue_last_col_d = (c_q == k_q - AWIDTH'(1));
    assign issue_last_row_d = (r_q == n_q - AWIDTH'(1));
    assign ret_fire_d       = dot_ovalid && (state_q != IDLE);
    assign ret_last_col_d   = (rc_q == k_q - AWIDTH'(1));
    assign ret_last_row_d   = (rr_q == n_q - AWIDTH'(1));
    assign sum_d            = (rc_q == '0) ? dot_result : acc_q + dot_result;

    // Memory data lands one cycle after mem_ren, so dot_ivalid is just the delayed enable.
    assign dot_vec0   = mat_rdata;
    assign dot_vec1   = vec_rdata;
    assign dot_ivalid = ivalid_q;
    assign mem_ren    = mem_ren_q;
    assign mat_raddr  = mat_raddr_q;
    assign vec_raddr  = vec_raddr_q;
    assign res_data   = res_data_q;
    assign res_row    = res_row_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            k_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            addr_q      <= '0;
            rc_q        <= '0;
            rr_q        <= '0;
            acc_q       <= '0;
            mem_ren_q   <= 1'b0;
            ivalid_q    <= 1'b0;
            mat_raddr_q <= '0;
            vec_raddr_q <= '0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_ren_q   <= 1'b0;
            res_valid_q <= 1'b0;
            ivalid_q    <= mem_ren_q;
            busy_q      <= (state_q != IDLE);
            done_q      <= (state_q == DONE);

            // Return side runs independently of the issue counters; products arrive in order.
            if (ret_fire_d) begin
                acc_q <= sum_d;
                if (ret_last_col_d) begin
                    rc_q        <= '0;
                    rr_q        <= rr_q + AWIDTH'(1);
                    res_valid_q <= 1'b1;
                    res_data_q  <= sum_d;
                    res_row_q   <= rr_q;
                end else begin
                    rc_q <= rc_q + AWIDTH'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q    <= num_rows;
                        k_q    <= num_chunks;
                        c_q    <= '0;
                        r_q    <= '0;
                        addr_q <= '0;
                        rc_q   <= '0;
                        rr_q   <= '0;
                        acc_q  <= '0;
                        state_q <= (num_rows == '0 || num_chunks == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    mem_ren_q   <= 1'b1;
                    mat_raddr_q <= addr_q;
                    vec_raddr_q <= c_q;
                    addr_q      <= addr_q + AWIDTH'(1);
                    if (issue_last_col_d) begin
                        c_q <= '0;
                        r_q <= r_q + AWIDTH'(1);
                        if (issue_last_row_d) begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        c_q <= c_q + AWIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (ret_fire_d && ret_last_col_d && ret_last_row_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl with a behavioural dot8 pipeline and 1-cycle memories.
module tb_mvm_ctrl;
    import mvm_pkg::*;

    localparam int IW = 8;
    localparam int OW = 16;
    localparam int AW = 9;
    localparam int RES_LAT = MEM_LATENCY + DOT_LATENCY + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     num_rows = '0;
    logic [AW-1:0]     num_chunks = '0;
    logic [AW-1:0]     mat_raddr, vec_raddr;
    logic              mem_ren;
    logic [8*IW-1:0]   mat_rdata = '0;
    logic [8*IW-1:0]   vec_rdata = '0;
    logic [8*IW-1:0]   dot_vec0, dot_vec1;
    logic              dot_ivalid;
    logic [OW-1:0]     dot_result;
    logic              dot_ovalid;
    logic [OW-1:0]     res_data;
    logic [AW-1:0]     res_row;
    logic              res_valid, busy, done;

    mvm_ctrl #(.IWIDTH(IW), .OWIDTH(OW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .num_rows(num_rows), .num_chunks(num_chunks),
        .mat_raddr(mat_raddr), .vec_raddr(vec_raddr), .mem_ren(mem_ren),
        .mat_rdata(mat_rdata), .vec_rdata(vec_rdata),
        .dot_vec0(dot_vec0), .dot_vec1(dot_vec1), .dot_ivalid(dot_ivalid),
        .dot_result(dot_result), .dot_ovalid(dot_ovalid),
        .res_data(res_data), .res_row(res_row), .res_valid(res_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Current job's memory contents, generated from the address.
    int cur_n = 0, cur_k = 1, cur_scale = 0, cur_vecv = 0;
    bit cur_rowdep = 1'b0;

    function automatic logic [8*IW-1:0] mat_word(input logic [AW-1:0] a);
        int row;
        int e;
        row = (cur_k == 0) ? 0 : int'(a) / cur_k;
        e   = cur_rowdep ? cur_scale * (row + 1) : cur_scale;
        return {8{e[7:0]}};
    endfunction

    function automatic logic [OW-1:0] dot8(input logic [8*IW-1:0] a, input logic [8*IW-1:0] b);
        int s;
        s = 0;
        for (int l = 0; l < 8; l++) s += int'(a[l*IW +: IW]) * int'(b[l*IW +: IW]);
        return s[OW-1:0];
    endfunction

    always @(posedge clk) begin
        if (mem_ren) begin
            mat_rdata <= mat_word(mat_raddr);
            vec_rdata <= {8{cur_vecv[7:0]}};
        end
    end

    logic [OW-1:0] pipe_d [DOT_LATENCY];
    logic          pipe_v [DOT_LATENCY];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DOT_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= dot_ivalid;
            pipe_d[0] <= dot8(dot_vec0, dot_vec1);
            for (int i = 1; i < DOT_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end
    assign dot_ovalid = pipe_v[DOT_LATENCY-1];
    assign dot_result = pipe_d[DOT_LATENCY-1];

    // Monitor: records events relative to the start-accepting edge.
    bit mon_en = 1'b0;
    int t0 = 0, mon_rel = 0, rd_cnt = 0, addr_bad = 0, busy_mid = 0;
    int rq_data[$], rq_row[$], rq_cyc[$], dq_cyc[$];

    always @(negedge clk) begin
        if (mon_en) begin
            mon_rel = edge_cnt - t0;
            if (mon_rel == 2) busy_mid = int'(busy);
            if (res_valid) begin
                rq_data.push_back(int'(res_data));
                rq_row.push_back(int'(res_row));
                rq_cyc.push_back(mon_rel);
            end
            if (done) dq_cyc.push_back(mon_rel);
            if (mem_ren) begin
                if (int'(mat_raddr) != rd_cnt || int'(vec_raddr) != rd_cnt % cur_k) addr_bad++;
                rd_cnt++;
            end
        end
    end

    int errors = 0, checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int k;
        int scale;
        bit rowdep;
        int vecv;
        int exp_data[5];
    } vec_t;

    task automatic run_job(input vec_t v, input int restart_at, input int rst_at, input string tag);
        int exp_cnt, nres, budget;
        cur_n = v.n; cur_k = (v.k == 0) ? 1 : v.k;
        cur_scale = v.scale; cur_rowdep = v.rowdep; cur_vecv = v.vecv;
        rq_data.delete(); rq_row.delete(); rq_cyc.delete(); dq_cyc.delete();
        rd_cnt = 0; addr_bad = 0; busy_mid = 0;
        @(negedge clk);
        num_rows = AW'(v.n);
        num_chunks = AW'(v.k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = edge_cnt;
        mon_en = 1'b1;
        num_rows = AW'(7);
        num_chunks = AW'(3);
        budget = v.n * v.k + RES_LAT + 12;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == restart_at) start = 1'b1;
            if (i == restart_at + 1) start = 1'b0;
            if (rst_at > 0 && i == rst_at - 1) rst = 1'b1;
            if (rst_at > 0 && i == rst_at) begin
                rst = 1'b0;
                check({tag, " rst_outputs"},
                      longint'({mem_ren, dot_ivalid, res_valid, done, busy,
                                mat_raddr, vec_raddr, res_data, res_row}), 0);
            end
        end
        mon_en = 1'b0;

        if (v.n == 0 || v.k == 0) exp_cnt = 0;
        else if (rst_at > 0) begin
            exp_cnt = 0;
            for (int r = 0; r < v.n; r++) if ((r + 1) * v.k + RES_LAT < rst_at) exp_cnt++;
        end else exp_cnt = v.n;

        nres = rq_data.size();
        check({tag, " res_count"}, nres, exp_cnt);
        for (int i = 0; i < nres && i < exp_cnt; i++) begin
            $display("%s row %0d: data=%0d row=%0d cycle=%0d", tag, i, rq_data[i], rq_row[i], rq_cyc[i]);
            check({tag, " res_data"}, rq_data[i], v.exp_data[i]);
            check({tag, " res_row"}, rq_row[i], i);
            check({tag, " res_cycle"}, rq_cyc[i], (i + 1) * v.k + RES_LAT);
        end
        check({tag, " done_count"}, dq_cyc.size(), (rst_at > 0) ? 0 : 1);
        if (rst_at == 0 && dq_cyc.size() > 0)
            check({tag, " done_cycle"}, dq_cyc[0], (v.n == 0 || v.k == 0) ? 1 : v.n * v.k + RES_LAT + 1);
        check({tag, " read_count"}, rd_cnt, v.n * v.k);
        check({tag, " addr_errors"}, addr_bad, 0);
        if (v.n * v.k != 0) check({tag, " busy_mid"}, busy_mid, 1);
        check({tag, " busy_end"}, busy, 0);
    endtask

    vec_t tbl[6];
    vec_t extra;

    initial begin
        tbl[0] = '{n:1, k:1, scale:1,   rowdep:1'b0, vecv:1,   exp_data:'{8, 0, 0, 0, 0}};
        tbl[1] = '{n:3, k:2, scale:1,   rowdep:1'b1, vecv:2,   exp_data:'{32, 64, 96, 0, 0}};
        tbl[2] = '{n:0, k:4, scale:1,   rowdep:1'b0, vecv:1,   exp_data:'{0, 0, 0, 0, 0}};
        tbl[3] = '{n:1, k:3, scale:127, rowdep:1'b0, vecv:127, exp_data:'{59416, 0, 0, 0, 0}};
        tbl[4] = '{n:4, k:0, scale:1,   rowdep:1'b0, vecv:1,   exp_data:'{0, 0, 0, 0, 0}};
        tbl[5] = '{n:2, k:3, scale:1,   rowdep:1'b1, vecv:3,   exp_data:'{72, 144, 0, 0, 0}};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              longint'({mem_ren, dot_ivalid, res_valid, done, busy,
                        mat_raddr, vec_raddr, res_data, res_row}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) run_job(tbl[t], 0, 0, $sformatf("vec%0d", t));

        extra = '{n:5, k:1, scale:1, rowdep:1'b0, vecv:1, exp_data:'{8, 8, 8, 8, 8}};
        run_job(extra, 3, 0, "restart");

        extra = '{n:4, k:2, scale:1, rowdep:1'b0, vecv:1, exp_data:'{16, 16, 16, 16, 0}};
        run_job(extra, 0, 10, "rst_drain");
        run_job(tbl[1], 0, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
